tl45_div_unit: RTL and testbench

TL45_DIV_UNIT -- requirements
Module: tl45_div_unit

---
 rtl/tl45_div_unit.sv | 93 +++++++++
 tb/tb_tl45_div_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/tl45_div_unit.sv
// rtl/tl45_div_unit.sv - multi-cycle restoring divider, signed/unsigned, one quotient bit per cycle
module tl45_div_unit #(
  parameter int BW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic          i_signed,
  input  logic [BW-1:0] i_numerator,
  input  logic [BW-1:0] i_denominator,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [BW-1:0] o_quotient
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state = IDLE;
  state_t        state_nxt;
  logic [BW-1:0] num   = '0;
  logic [BW-1:0] den   = '0;
  logic [BW:0]   rem   = '0;
  logic [BW-1:0] quo   = '0;
  logic [BW-1:0] cnt   = '0;
  logic          neg   = 1'b0;
  logic          err   = 1'b0;

  logic          accept;
  logic [BW+1:0] trial;
  logic          ge;
  logic [BW-1:0] num_abs;
  logic [BW-1:0] den_abs;

  assign accept = (state == IDLE) && i_wr;

  // Magnitudes in signed mode; -2^(BW-1) maps onto itself as an unsigned value.
  assign num_abs = (i_signed && i_numerator[BW-1])   ? -i_numerator   : i_numerator;
  assign den_abs = (i_signed && i_denominator[BW-1]) ? -i_denominator : i_denominator;

  // Trial subtraction is one bit wider than the remainder so its MSB is a clean borrow.
  assign trial = {rem, num[BW-1]} - {2'b00, den};
  assign ge    = ~trial[BW+1];

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_wr) state_nxt = (i_denominator == '0) ? DONE : CALC;
      CALC: if (cnt[BW-1]) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      num <= '0;
      den <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      neg <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      num <= num_abs;
      den <= den_abs;
      rem <= '0;
      quo <= '0;
      cnt <= {{(BW-1){1'b0}}, 1'b1};
      neg <= i_signed && (i_numerator[BW-1] ^ i_denominator[BW-1]);
      err <= (i_denominator == '0);
    end else if (state == CALC) begin
      num <= {num[BW-2:0], 1'b0};
      rem <= ge ? trial[BW:0] : {rem[BW-1:0], num[BW-1]};
      quo <= {quo[BW-2:0], ge};
      cnt <= {cnt[BW-2:0], 1'b0};
    end else if (state == FIX) begin
      if (neg) quo <= -quo;
    end
  end

  assign o_busy     = (state == CALC) || (state == FIX);
  assign o_valid    = (state == DONE);
  assign o_err      = err;
  assign o_quotient = quo;

endmodule

// File: tb/tb_tl45_div_unit.sv
// tb/tb_tl45_div_unit.sv - directed self-checking bench for tl45_div_unit
module tb_tl45_div_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr = 1'b0;
  logic        i_signed = 1'b0;
  logic [31:0] i_numerator = '0;
  logic [31:0] i_denominator = '0;
  logic        o_busy;
  logic        o_valid;
  logic        o_err;
  logic [31:0] o_quotient;

  int passed = 0;
  int total  = 0;

  tl45_div_unit #(.BW(32)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_wr(i_wr),
    .i_signed(i_signed),
    .i_numerator(i_numerator),
    .i_denominator(i_denominator),
    .o_busy(o_busy),
    .o_valid(o_valid),
    .o_err(o_err),
    .o_quotient(o_quotient)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Inputs change at negedges; cycle k is the negedge just before the k-th edge after accept.
  task automatic run(input string tag, input logic sg, input logic [31:0] n, input logic [31:0] d,
                     input int inj_cyc, input int rst_cyc,
                     input int exp_lat, input logic [31:0] exp_q, input logic exp_err);
    int  first_valid;
    int  valid_cnt;
    logic overlap, busy_c1, busy_any;
    first_valid = 0; valid_cnt = 0; overlap = 0; busy_c1 = 0; busy_any = 0;
    @(negedge i_clk);
    i_wr = 1'b1; i_signed = sg; i_numerator = n; i_denominator = d;
    @(posedge i_clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge i_clk);
      i_wr = 1'b0;
      i_reset = 1'b0;
      if (cyc == inj_cyc) begin
        i_wr = 1'b1; i_signed = 1'b0; i_numerator = 32'd9; i_denominator = 32'd3;
      end
      if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
        check({tag, "_rst_busy"},  {31'b0, o_busy}, 32'd0);
        check({tag, "_rst_valid"}, {31'b0, o_valid}, 32'd0);
        check({tag, "_rst_err"},   {31'b0, o_err}, 32'd0);
        check({tag, "_rst_quot"},  o_quotient, 32'd0);
      end
      if (cyc == rst_cyc) i_reset = 1'b1;
      if (cyc == 1) busy_c1 = o_busy;
      if (o_busy) busy_any = 1'b1;
      if (o_busy && o_valid) overlap = 1'b1;
      if (o_valid) begin
        valid_cnt++;
        if (first_valid == 0) first_valid = cyc;
      end
    end
    i_wr = 1'b0; i_reset = 1'b0;
    check({tag, "_latency"},  first_valid, exp_lat);
    check({tag, "_nvalid"},   valid_cnt, (exp_lat == 0) ? 32'd0 : 32'd1);
    check({tag, "_overlap"},  {31'b0, overlap}, 32'd0);
    check({tag, "_busy_c1"},  {31'b0, busy_c1}, {31'b0, (d != 0)});
    check({tag, "_busy_any"}, {31'b0, busy_any}, {31'b0, (d != 0)});
    check({tag, "_quot"},     o_quotient, exp_q);
    check({tag, "_err"},      {31'b0, o_err}, {31'b0, exp_err});
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_busy",  {31'b0, o_busy}, 32'd0);
    check("reset_valid", {31'b0, o_valid}, 32'd0);
    check("reset_err",   {31'b0, o_err}, 32'd0);
    check("reset_quot",  o_quotient, 32'd0);
    i_reset = 1'b0;

    run("u100_7",    1'b0, 32'd100,      32'd7,          0, 0, 34, 32'd14,       1'b0);
    run("sm100_7",   1'b1, 32'hFFFFFF9C, 32'd7,          0, 0, 34, 32'hFFFFFFF2, 1'b0);
    run("sm100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   0, 0, 34, 32'd14,       1'b0);
    run("umax_1",    1'b0, 32'hFFFFFFFF, 32'd1,          0, 0, 34, 32'hFFFFFFFF, 1'b0);
    run("smin_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF,   0, 0, 34, 32'h80000000, 1'b0);
    run("s7_m2",     1'b1, 32'd7,        32'hFFFFFFFE,   0, 0, 34, 32'hFFFFFFFD, 1'b0);
    run("u5_0",      1'b0, 32'd5,        32'd0,          0, 0, 1,  32'd0,        1'b1);
    run("s5_0",      1'b1, 32'd5,        32'd0,          0, 0, 1,  32'd0,        1'b1);
    run("u1000_10",  1'b0, 32'd1000,     32'd10,        10, 0, 34, 32'd100,      1'b0);
    run("rst_mid",   1'b0, 32'd1000,     32'd10,         0, 15, 0, 32'd0,        1'b0);
    run("u9_3",      1'b0, 32'd9,        32'd3,          0, 0, 34, 32'd3,        1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
